// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage: walks an already key-scheduled S box,
// swaps entries byte by byte and XORs the keystream with ciphertext from ROM,
// writing plaintext to RAM. S and ROM are synchronous-read memories, so every
// read is split into an address cycle and a latch cycle.
module prga_decrypt #(
   parameter int  MSG_LENGTH = 32,
   localparam int AW = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
   input  logic          CLOCK_50,
   input  logic          reset_n,
   input  logic          start,
   output logic          done,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    s_q,
   output logic [AW-1:0] rom_address,
   input  logic [7:0]    rom_q,
   output logic [AW-1:0] ram_address,
   output logic [7:0]    ram_data,
   output logic          ram_wren
);

   localparam logic [AW-1:0] K_LAST = AW'(MSG_LENGTH - 1);

   typedef enum logic [3:0] {
      IDLE, RD_SI, LT_SI, RD_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, LT_F, WR_OUT, DONE
   } state_t;

   state_t        r_state;
   logic [7:0]    r_i;
   logic [7:0]    r_j;
   logic [AW-1:0] r_k;
   logic [7:0]    r_si;
   logic [7:0]    r_sj;
   logic [7:0]    r_f;
   logic [7:0]    r_ct;
   logic          r_done;
   logic          r_s_wren;
   logic          r_ram_wren;
   logic [7:0]    r_s_address;
   logic [7:0]    r_s_data;
   logic [AW-1:0] r_rom_address;
   logic [AW-1:0] r_ram_address;

   // All S-box index arithmetic wraps at 256; no carry is ever kept.
   function automatic logic [7:0] wrap_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[7:0];
   endfunction

   // Sequencer: outputs are registered, so each state's bus values are loaded
   // on the edge that enters that state; anything not written goes back to 0.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_i           <= 8'd0;
         r_j           <= 8'd0;
         r_k           <= '0;
         r_si          <= 8'd0;
         r_sj          <= 8'd0;
         r_f           <= 8'd0;
         r_ct          <= 8'd0;
         r_done        <= 1'b0;
         r_s_wren      <= 1'b0;
         r_ram_wren    <= 1'b0;
         r_s_address   <= 8'd0;
         r_s_data      <= 8'd0;
         r_rom_address <= '0;
         r_ram_address <= '0;
      end else begin
         r_done        <= 1'b0;
         r_s_wren      <= 1'b0;
         r_ram_wren    <= 1'b0;
         r_s_address   <= 8'd0;
         r_s_data      <= 8'd0;
         r_rom_address <= '0;
         r_ram_address <= '0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  // A restart from DONE keeps S as the previous run left it.
                  r_k         <= '0;
                  r_j         <= 8'd0;
                  r_i         <= 8'd1;
                  r_s_address <= 8'd1;
                  r_state     <= RD_SI;
               end else begin
                  r_done <= (r_state == DONE);
               end
            end
            RD_SI: r_state <= LT_SI;
            LT_SI: begin
               r_si        <= s_q;
               r_j         <= wrap_add8(r_j, s_q);
               r_s_address <= wrap_add8(r_j, s_q);
               r_state     <= RD_SJ;
            end
            RD_SJ: r_state <= LT_SJ;
            LT_SJ: begin
               // When i == j both swap writes carry the same value, leaving S intact.
               r_sj        <= s_q;
               r_s_address <= r_i;
               r_s_data    <= s_q;
               r_s_wren    <= 1'b1;
               r_state     <= WR_SI;
            end
            WR_SI: begin
               r_s_address <= r_j;
               r_s_data    <= r_si;
               r_s_wren    <= 1'b1;
               r_state     <= WR_SJ;
            end
            WR_SJ: begin
               r_s_address   <= wrap_add8(r_si, r_sj);
               r_rom_address <= r_k;
               r_state       <= RD_F;
            end
            RD_F: r_state <= LT_F;
            LT_F: begin
               r_f           <= s_q;
               r_ct          <= rom_q;
               r_ram_address <= r_k;
               r_ram_wren    <= 1'b1;
               r_state       <= WR_OUT;
            end
            WR_OUT: begin
               if (r_k == K_LAST) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_k         <= r_k + 1'b1;
                  r_i         <= wrap_add8(r_i, 8'd1);
                  r_s_address <= wrap_add8(r_i, 8'd1);
                  r_state     <= RD_SI;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign done        = r_done;
   assign s_address   = r_s_address;
   assign s_data      = r_s_data;
   assign s_wren      = r_s_wren;
   assign rom_address = r_rom_address;
   assign ram_address = r_ram_address;
   // Plaintext comes straight from the latched keystream and ciphertext bytes.
   assign ram_data    = r_ram_wren ? (r_f ^ r_ct) : 8'd0;
   assign ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt with MSG_LENGTH=4: S, ROM and RAM are modelled here,
// an RC4 reference predicts every S/RAM write, and directed runs cover the
// identity-S vectors, restart from DONE, start spamming and reset mid-run.
module tb_prga_decrypt;
   localparam int N  = 4;
   localparam int AW = 2;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n;
   logic          start;
   logic          done;
   logic [7:0]    s_address;
   logic [7:0]    s_data;
   logic          s_wren;
   logic [7:0]    s_q;
   logic [AW-1:0] rom_address;
   logic [7:0]    rom_q;
   logic [AW-1:0] ram_address;
   logic [7:0]    ram_data;
   logic          ram_wren;

   prga_decrypt #(.MSG_LENGTH(N)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .start      (start),
      .done       (done),
      .s_address  (s_address),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .s_q        (s_q),
      .rom_address(rom_address),
      .rom_q      (rom_q),
      .ram_address(ram_address),
      .ram_data   (ram_data),
      .ram_wren   (ram_wren)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [7:0] s_mem   [256];
   logic [7:0] rom_mem [N];
   logic [7:0] ram_mem [N];

   // Synchronous-read memories around the DUT.
   always @(posedge CLOCK_50) begin
      s_q   <= s_mem[s_address];
      rom_q <= rom_mem[rom_address];
      if (s_wren)   s_mem[s_address]     <= s_data;
      if (ram_wren) ram_mem[ram_address] <= ram_data;
   end

   typedef struct {
      int a;
      int d;
   } wr_t;

   int  mdl_S   [256];
   int  mdl_rom [N];
   int  exp_ram [N];
   wr_t exp_sw[$];
   wr_t exp_rw[$];
   wr_t sw_log[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic init_mem(input int rom_val);
      for (int x = 0; x < 256; x++) begin
         s_mem[x] <= 8'(x);
         mdl_S[x] = x;
      end
      for (int k = 0; k < N; k++) begin
         rom_mem[k] <= 8'(rom_val);
         ram_mem[k] <= 8'hAA;
         mdl_rom[k] = rom_val;
      end
   endtask

   // Reference RC4 PRGA over the bench's copy of S; queues every expected write.
   task automatic model_load();
      int  i, j, t, f;
      wr_t w;
      j = 0;
      for (int k = 0; k < N; k++) begin
         i = (k + 1) % 256;
         j = (j + mdl_S[i]) % 256;
         w.a = i; w.d = mdl_S[j]; exp_sw.push_back(w);
         w.a = j; w.d = mdl_S[i]; exp_sw.push_back(w);
         t = mdl_S[i]; mdl_S[i] = mdl_S[j]; mdl_S[j] = t;
         f = mdl_S[(mdl_S[i] + mdl_S[j]) % 256];
         exp_ram[k] = f ^ mdl_rom[k];
         w.a = k; w.d = exp_ram[k]; exp_rw.push_back(w);
      end
   endtask

   // Pulse start, optionally keep toggling it mid-run, and time the done edge.
   task automatic run(input bit spam, input string tag);
      int n;
      @(negedge CLOCK_50) start = 1'b1;
      @(posedge CLOCK_50);
      #1 start = 1'b0;
      check({tag, "_done_low_after_start"}, 32'(done), 0);
      n = 0;
      while (n < 2000) begin
         @(negedge CLOCK_50);
         n++;
         if (done) break;
         start = spam ? n[0] : 1'b0;
      end
      start = 1'b0;
      check({tag, "_done_latency"}, n, 9 * N + 1);
   endtask

   task automatic check_results(input string tag);
      int bad;
      for (int k = 0; k < N; k++)
         check({tag, "_ram_vs_model"}, 32'(ram_mem[k]), exp_ram[k]);
      bad = 0;
      for (int x = 0; x < 256; x++)
         if (32'(s_mem[x]) !== mdl_S[x]) bad++;
      check({tag, "_s_entries_differing_from_model"}, bad, 0);
      check({tag, "_s_writes_missing"}, exp_sw.size(), 0);
      check({tag, "_ram_writes_missing"}, exp_rw.size(), 0);
   endtask

   // Every cycle: each write must be the next one the model predicts, and idle buses sit at 0.
   always @(negedge CLOCK_50) begin : cmp
      wr_t w, e;
      if (chk_en && reset_n === 1'b1) begin
         if (s_wren) begin
            w.a = 32'(s_address); w.d = 32'(s_data);
            sw_log.push_back(w);
            if (exp_sw.size() == 0) check("s_wren_unexpected", 1, 0);
            else begin
               e = exp_sw.pop_front();
               check("s_wr_addr", w.a, e.a);
               check("s_wr_data", w.d, e.d);
            end
         end else begin
            check("s_data_idle", 32'(s_data), 0);
         end
         if (ram_wren) begin
            w.a = 32'(ram_address); w.d = 32'(ram_data);
            if (exp_rw.size() == 0) check("ram_wren_unexpected", 1, 0);
            else begin
               e = exp_rw.pop_front();
               check("ram_wr_addr", w.a, e.a);
               check("ram_wr_data", w.d, e.d);
            end
         end else begin
            check("ram_bus_idle", 32'({ram_address, ram_data}), 0);
         end
         if (done) check("wren_in_done", 32'({s_wren, ram_wren}), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      #2;
      check("rst_done",        32'(done), 0);
      check("rst_s_wren",      32'(s_wren), 0);
      check("rst_ram_wren",    32'(ram_wren), 0);
      check("rst_s_address",   32'(s_address), 0);
      check("rst_s_data",      32'(s_data), 0);
      check("rst_rom_address", 32'(rom_address), 0);
      check("rst_ram_address", 32'(ram_address), 0);
      check("rst_ram_data",    32'(ram_data), 0);
      init_mem(0);
      repeat (3) @(negedge CLOCK_50);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Identity S, ciphertext all zero.
      model_load();
      check("A_model_pt0", exp_ram[0], 32'h02);
      check("A_model_pt1", exp_ram[1], 32'h05);
      check("A_model_pt2", exp_ram[2], 32'h07);
      check("A_model_pt3", exp_ram[3], 32'h0D);
      sw_log.delete();
      run(1'b0, "A");
      check_results("A");
      check("A_ram0", 32'(ram_mem[0]), 32'h02);
      check("A_ram1", 32'(ram_mem[1]), 32'h05);
      check("A_ram2", 32'(ram_mem[2]), 32'h07);
      check("A_ram3", 32'(ram_mem[3]), 32'h0D);
      check("A_S1", 32'(s_mem[1]), 1);
      check("A_S2", 32'(s_mem[2]), 3);
      check("A_S3", 32'(s_mem[3]), 5);
      check("A_S4", 32'(s_mem[4]), 9);
      check("A_S5", 32'(s_mem[5]), 2);
      check("A_S9", 32'(s_mem[9]), 4);
      check("A_log_count", sw_log.size(), 2 * N);
      check("A_first_swap_wr0", 32'({sw_log[0].a[7:0], sw_log[0].d[7:0]}), 32'h0101);
      check("A_first_swap_wr1", 32'({sw_log[1].a[7:0], sw_log[1].d[7:0]}), 32'h0101);

      // Restart from DONE on the permuted S.
      model_load();
      run(1'b0, "C");
      check_results("C");

      // Fresh identity S, ciphertext all 0xFF, start toggled throughout the run.
      @(negedge CLOCK_50) reset_n = 1'b0;
      init_mem(255);
      @(negedge CLOCK_50) reset_n = 1'b1;
      model_load();
      check("B_model_pt0", exp_ram[0], 32'hFD);
      check("B_model_pt3", exp_ram[3], 32'hF2);
      run(1'b1, "B");
      check_results("B");
      check("B_ram0", 32'(ram_mem[0]), 32'hFD);
      check("B_ram1", 32'(ram_mem[1]), 32'hFA);
      check("B_ram2", 32'(ram_mem[2]), 32'hF8);
      check("B_ram3", 32'(ram_mem[3]), 32'hF2);

      // Reset during WR_SI of byte 2 abandons the run.
      @(negedge CLOCK_50) reset_n = 1'b0;
      init_mem(0);
      @(negedge CLOCK_50) reset_n = 1'b1;
      model_load();
      @(negedge CLOCK_50) start = 1'b1;
      @(posedge CLOCK_50);
      #1 start = 1'b0;
      repeat (23) @(negedge CLOCK_50);
      check("D_in_wr_si_wren", 32'(s_wren), 1);
      check("D_in_wr_si_addr", 32'(s_address), 3);
      check("D_in_wr_si_data", 32'(s_data), 5);
      #1 reset_n = 1'b0;
      #1;
      check("D_async_s_wren",    32'(s_wren), 0);
      check("D_async_s_address", 32'(s_address), 0);
      check("D_async_s_data",    32'(s_data), 0);
      check("D_async_done",      32'(done), 0);
      exp_sw.delete();
      exp_rw.delete();
      @(negedge CLOCK_50) reset_n = 1'b1;
      repeat (50) begin
         @(negedge CLOCK_50);
         check("D_done_stays_low", 32'(done), 0);
      end
      check("D_ram0", 32'(ram_mem[0]), 32'h02);
      check("D_ram1", 32'(ram_mem[1]), 32'h05);
      check("D_ram2_untouched", 32'(ram_mem[2]), 32'hAA);
      check("D_ram3_untouched", 32'(ram_mem[3]), 32'hAA);
      check("D_S2", 32'(s_mem[2]), 3);
      check("D_S3", 32'(s_mem[3]), 2);
      check("D_S5", 32'(s_mem[5]), 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
